// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button / switch debouncer bank.
package debounce_pkg;

    typedef enum logic [1:0] {LOW, PRESSED, HELD} press_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, settle counter, and a press FSM
// that adds long-press detection and optional auto-repeat.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 65536,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic bouncy,
    output logic clean,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic held,
    output logic held_pulse,
    output logic repeat_pulse
);
    localparam int SW = cnt_width(STABLE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    // Keep the repeat counter at least one bit wide even when repeat is disabled.
    localparam int RW = (REPEAT_CYCLES > 0) ? cnt_width(REPEAT_CYCLES) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = (REPEAT_CYCLES > 0) ? RW'(REPEAT_CYCLES - 1) : '0;

    logic [1:0]    sync;
    logic          s;
    logic [SW-1:0] scnt;
    logic          settle_hit, rise_evt, fall_evt;

    assign s          = sync[1];
    assign settle_hit = (s != clean) && (scnt == S_LAST);
    assign rise_evt   = settle_hit & s;
    assign fall_evt   = settle_hit & ~s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= '0;
            scnt       <= '0;
            clean      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync       <= {sync[0], bouncy};
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (s == clean) begin
                scnt <= '0;
            end else if (scnt == S_LAST) begin
                clean      <= s;
                scnt       <= '0;
                rise_pulse <= s;
                fall_pulse <= ~s;
            end else begin
                scnt <= scnt + 1'b1;
            end
        end
    end

    press_state_t  state, state_d;
    logic [HW-1:0] hcnt, hcnt_d;
    logic [RW-1:0] rcnt, rcnt_d;
    logic          held_pulse_d, repeat_pulse_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOW;
            hcnt         <= '0;
            rcnt         <= '0;
            held_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_d;
            hcnt         <= hcnt_d;
            rcnt         <= rcnt_d;
            held_pulse   <= held_pulse_d;
            repeat_pulse <= repeat_pulse_d;
        end
    end

    // A release always wins over a hold or repeat expiring on the same edge.
    always_comb begin
        state_d        = state;
        hcnt_d         = hcnt;
        rcnt_d         = rcnt;
        held_pulse_d   = 1'b0;
        repeat_pulse_d = 1'b0;
        if (fall_evt) begin
            state_d = LOW;
            hcnt_d  = '0;
            rcnt_d  = '0;
        end else begin
            case (state)
                LOW: begin
                    if (rise_evt) begin
                        state_d = PRESSED;
                        hcnt_d  = '0;
                    end
                end
                PRESSED: begin
                    if (hcnt == H_LAST) begin
                        state_d      = HELD;
                        held_pulse_d = 1'b1;
                        rcnt_d       = '0;
                    end else begin
                        hcnt_d = hcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (REPEAT_CYCLES > 0) begin
                        if (rcnt == R_LAST) begin
                            rcnt_d         = '0;
                            repeat_pulse_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt + 1'b1;
                        end
                    end
                end
                default: state_d = LOW;
            endcase
        end
    end

    assign held = (state == HELD);

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels between the board pins and front-panel logic.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 65536,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] bouncy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] held_pulse,
    output logic [N_CH-1:0] repeat_pulse
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .bouncy      (bouncy_in[i]),
            .clean       (clean_out[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .held        (held[i]),
            .held_pulse  (held_pulse[i]),
            .repeat_pulse(repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: a repeat-enabled and a repeat-disabled instance share
// the same pins and are checked every cycle against an edge-indexed model.
module tb_debounce_bank;
    localparam int N_CH = 2;
    localparam int S    = 4;
    localparam int H    = 10;
    localparam int RA   = 3;
    localparam int MAXE = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_CH-1:0] bouncy_in = '0;

    logic [N_CH-1:0] a_clean, a_rise, a_fall, a_held, a_hp, a_rp;
    logic [N_CH-1:0] b_clean, b_rise, b_fall, b_held, b_hp, b_rp;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(N_CH), .STABLE_CYCLES(S), .HOLD_CYCLES(H), .REPEAT_CYCLES(RA)) dut_a (
        .clk(clk), .rst(rst), .bouncy_in(bouncy_in), .clean_out(a_clean), .rise_pulse(a_rise),
        .fall_pulse(a_fall), .held(a_held), .held_pulse(a_hp), .repeat_pulse(a_rp));

    debounce_bank #(.N_CH(N_CH), .STABLE_CYCLES(S), .HOLD_CYCLES(H), .REPEAT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bouncy_in(bouncy_in), .clean_out(b_clean), .rise_pulse(b_rise),
        .fall_pulse(b_fall), .held(b_held), .held_pulse(b_hp), .repeat_pulse(b_rp));

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    // Model state: pin samples per edge since reset, plus expected outputs.
    logic [N_CH-1:0] phist [0:MAXE-1];
    logic [N_CH-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_held = '0, m_hp = '0, m_rp = '0;
    int rise_edge [N_CH];

    // Event log from the DUT outputs, used by the literal checks.
    int a_rise_n [N_CH], a_rise_at [N_CH], a_fall_at [N_CH], a_hp_n [N_CH], a_hp_at [N_CH];
    int a_rp_n [N_CH], a_rp_at [N_CH], a_hdrop_at [N_CH], b_hp_n [N_CH], b_rp_n [N_CH];
    logic [N_CH-1:0] a_held_prev = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Synchronised level seen by the edge j logic: the pin as sampled two edges earlier.
    function automatic logic s_pre(input int j, input int c);
        if (j - 2 >= 1 && j - 2 < MAXE) return phist[j-2][c];
        return 1'b0;
    endfunction

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic model_edge();
        logic flip;
        int d;
        cyc++;
        if (cyc < MAXE) phist[cyc] = bouncy_in;
        for (int c = 0; c < N_CH; c++) begin
            // Level flips once the last S synchronised samples all disagree with it.
            flip = 1'b1;
            for (int j = cyc - S + 1; j <= cyc; j++)
                if (s_pre(j, c) == m_clean[c]) flip = 1'b0;
            m_rise[c] = flip & ~m_clean[c];
            m_fall[c] = flip & m_clean[c];
            if (flip) m_clean[c] = ~m_clean[c];
            if (m_rise[c]) rise_edge[c] = cyc;
            d = cyc - rise_edge[c];
            m_held[c] = m_clean[c] && d >= H;
            m_hp[c]   = m_clean[c] && d == H;
            m_rp[c]   = m_clean[c] && d > H && ((d - H) % RA) == 0;
        end
    endtask

    task automatic compare_and_log();
        check("dut_a_outputs", {20'd0, a_clean, a_rise, a_fall, a_held, a_hp, a_rp},
              {20'd0, m_clean, m_rise, m_fall, m_held, m_hp, m_rp});
        check("dut_b_outputs", {20'd0, b_clean, b_rise, b_fall, b_held, b_hp, b_rp},
              {20'd0, m_clean, m_rise, m_fall, m_held, m_hp, 2'b00});
        for (int c = 0; c < N_CH; c++) begin
            if (a_rise[c]) begin a_rise_n[c]++; a_rise_at[c] = cyc; end
            if (a_fall[c]) a_fall_at[c] = cyc;
            if (a_hp[c]) begin a_hp_n[c]++; a_hp_at[c] = cyc; end
            if (a_rp[c]) begin a_rp_n[c]++; a_rp_at[c] = cyc; end
            if (a_held_prev[c] && !a_held[c]) a_hdrop_at[c] = cyc;
            if (b_hp[c]) b_hp_n[c]++;
            if (b_rp[c]) b_rp_n[c]++;
        end
        a_held_prev = a_held;
    endtask

    initial begin
        int t0, r0, r1, h0, h1, p0, p1, bh0, bh1, bp0, bp1;
        for (int c = 0; c < N_CH; c++) begin
            rise_edge[c] = 0; a_rise_n[c] = 0; a_rise_at[c] = -1; a_fall_at[c] = -1;
            a_hp_n[c] = 0; a_hp_at[c] = -1; a_rp_n[c] = 0; a_rp_at[c] = -1;
            a_hdrop_at[c] = -1; b_hp_n[c] = 0; b_rp_n[c] = 0;
        end
        fork
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    cyc = 0; m_clean = '0; m_rise = '0; m_fall = '0;
                    m_held = '0; m_hp = '0; m_rp = '0;
                end else begin
                    model_edge();
                end
            end
            forever begin
                @(negedge clk);
                compare_and_log();
            end
        join_none

        // Reset state
        tick(3);
        check("reset_a", {20'd0, a_clean, a_rise, a_fall, a_held, a_hp, a_rp}, 32'd0);
        check("reset_b", {20'd0, b_clean, b_rise, b_fall, b_held, b_hp, b_rp}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // Clean step then long press on ch0
        t0 = cyc; r0 = a_rise_n[0]; r1 = a_rise_n[1]; h0 = a_hp_n[0]; p0 = a_rp_n[0];
        bh0 = b_hp_n[0]; bp0 = b_rp_n[0];
        bouncy_in[0] = 1'b1;
        tick(30);
        bouncy_in[0] = 1'b0;
        tick(12);
        check("step_rise_at", a_rise_at[0], t0 + 6);
        check("step_rise_count", a_rise_n[0] - r0, 1);
        check("step_ch1_quiet", a_rise_n[1] - r1, 0);
        check("long_held_at", a_hp_at[0], t0 + 16);
        check("long_held_count", a_hp_n[0] - h0, 1);
        check("long_repeat_count", a_rp_n[0] - p0, 6);
        check("long_repeat_last", a_rp_at[0], t0 + 34);
        check("long_fall_at", a_fall_at[0], t0 + 36);
        check("long_held_drop", a_hdrop_at[0], t0 + 36);
        check("norep_held_count", b_hp_n[0] - bh0, 1);
        check("norep_repeat_count", b_rp_n[0] - bp0, 0);

        // Bounce: 1,0,1 at 3-cycle spacing, then steady high
        t0 = cyc; r0 = a_rise_n[0]; h0 = a_hp_n[0];
        bouncy_in[0] = 1'b1; tick(3);
        bouncy_in[0] = 1'b0; tick(3);
        bouncy_in[0] = 1'b1; tick(8);
        bouncy_in[0] = 1'b0; tick(12);
        check("bounce_rise_count", a_rise_n[0] - r0, 1);
        check("bounce_rise_at", a_rise_at[0], t0 + 12);
        check("bounce_fall_at", a_fall_at[0], t0 + 20);
        check("bounce_no_held", a_hp_n[0] - h0, 0);

        // Release landing on the hold-expiry edge
        t0 = cyc; h0 = a_hp_n[0]; bh0 = b_hp_n[0];
        bouncy_in[0] = 1'b1; tick(10);
        bouncy_in[0] = 1'b0; tick(12);
        check("race_rise_at", a_rise_at[0], t0 + 6);
        check("race_fall_at", a_fall_at[0], t0 + 16);
        check("race_no_held_a", a_hp_n[0] - h0, 0);
        check("race_no_held_b", b_hp_n[0] - bh0, 0);

        // ch1 held 40 cycles on both instances
        t0 = cyc; h1 = a_hp_n[1]; p1 = a_rp_n[1]; bh1 = b_hp_n[1]; bp1 = b_rp_n[1];
        bouncy_in[1] = 1'b1; tick(40);
        bouncy_in[1] = 1'b0; tick(12);
        check("ch1_held_at", a_hp_at[1], t0 + 16);
        check("ch1_held_count", a_hp_n[1] - h1, 1);
        check("ch1_repeat_count", a_rp_n[1] - p1, 9);
        check("ch1_norep_held", b_hp_n[1] - bh1, 1);
        check("ch1_norep_repeat", b_rp_n[1] - bp1, 0);

        // Asynchronous reset while held, input left high
        bouncy_in[0] = 1'b1;
        tick(20);
        check("pre_reset_held", {31'd0, a_held[0]}, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_a", {20'd0, a_clean, a_rise, a_fall, a_held, a_hp, a_rp}, 32'd0);
        check("async_reset_b", {20'd0, b_clean, b_rise, b_fall, b_held, b_hp, b_rp}, 32'd0);
        repeat (3) @(negedge clk);
        r0 = a_rise_n[0];
        rst = 1'b0;
        tick(8);
        check("post_reset_rise_at", a_rise_at[0], 6);
        check("post_reset_rise_count", a_rise_n[0] - r0, 1);
        bouncy_in[0] = 1'b0;
        tick(10);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for the board's push-buttons and switches, from N asynchronous bouncy inputs to clean levels plus single-cycle event pulses. Each channel synchronises its input, requires a configurable run of consecutive differing samples before changing the clean level, and adds long-press ("held") detection with optional auto-repeat. It sits between the FPGA pins and the front-panel/control logic, so downstream code never needs its own edge detectors or timers.

## Interface
- `N_CH`, 4: number of independent channels.
- `STABLE_CYCLES`, 65536: consecutive cycles a new synchronised level must persist before `clean_out` changes. Must be ≥1.
- `HOLD_CYCLES`, 25_000_000: cycles `clean_out` must stay high before `held` asserts. Must be ≥1.
- `REPEAT_CYCLES`, 5_000_000: auto-repeat period while held. 0 disables repeat.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `bouncy_in`  in  N_CH  raw asynchronous inputs.
- `clean_out`  out  N_CH  debounced level.
- `rise_pulse`  out  N_CH  1-cycle pulse when `clean_out` goes 0→1.
- `fall_pulse`  out  N_CH  1-cycle pulse when `clean_out` goes 1→0.
- `held`  out  N_CH  level; high while the channel is in HELD.
- `held_pulse`  out  N_CH  1-cycle pulse on entry to HELD.
- `repeat_pulse`  out  N_CH  1-cycle pulse every REPEAT_CYCLES while in HELD.

## Operation
- Channels are fully independent and have no shared state.
- Synchroniser: 2 flops per channel. Its output is `s`.
- Settle counter `scnt`, width `$clog2(STABLE_CYCLES+1)`:
  - If `s == clean_out`: clear to 0.
  - Else if `scnt == STABLE_CYCLES-1`: set `clean_out <= s` and clear the counter.
  - Otherwise increment.
  - A single-cycle bounce back to the clean level restarts the count from 0.
- Press FSM, enum `{LOW, PRESSED, HELD}`:
  - LOW→PRESSED on the edge where `clean_out` becomes 1. `hcnt` clears.
  - PRESSED: `hcnt` increments each cycle. When `hcnt == HOLD_CYCLES-1`, go to HELD, assert `held_pulse` for 1 cycle, and clear `rcnt`.
  - HELD: when `REPEAT_CYCLES > 0`, `rcnt` increments. At `REPEAT_CYCLES-1`, pulse `repeat_pulse` and reload `rcnt` to 0.
  - Any state→LOW on the edge where `clean_out` becomes 0. `held` drops on that same edge.
- All counters saturate or reload explicitly; none ever wraps past its terminal value.
- Reset values: every output is 0. Sync flops, all counters and the FSM (LOW) are cleared. Reset mid-operation aborts any settle, hold or repeat in progress with no pulses emitted. After release, an input that is already high is treated as a new press and yields `rise_pulse`.

## Timing
- All pulses are registered and coincide with the cycle their triggering state change is visible.
- Latency: counting the first edge that samples the new pin level as edge 1, `clean_out` and the matching rise/fall pulse change on edge `STABLE_CYCLES+2`.
- Held latency: `held` and `held_pulse` assert `HOLD_CYCLES` edges after `clean_out` rises.
- First `repeat_pulse` comes `REPEAT_CYCLES` edges after `held_pulse`, then one every `REPEAT_CYCLES`.
- Release on the same edge as hold expiry: the fall takes priority. No `held_pulse`, and `fall_pulse` asserts.
- Release on the same edge as repeat expiry: no `repeat_pulse`.

## Structure
- `debounce_pkg` holds the press-state enum `press_state_t` and a `cnt_width(n)` function returning `$clog2(n+1)`.
- Sub-module `debounce_channel` contains one channel (synchroniser, settle counter, press FSM). `debounce_bank` instantiates it N_CH times with a generate loop and contains no other logic.

## Test plan
All scenarios use N_CH=2, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Clean step: ch0 goes 0→1 and stays high → `clean_out[0]` and `rise_pulse[0]` on edge 6, both 1 cycle for the pulse. ch1 outputs stay 0 throughout.
- Bounce: ch0 toggles 1,0,1 at 3-cycle spacing, then holds 1 → no output change until 4 stable synchronised cycles. Exactly one `rise_pulse`.
- Long press: hold ch0 high for 30 cycles → `held_pulse` 10 edges after the rise, then `repeat_pulse` at +3, +6, +9 and so on. The fall produces a `fall_pulse` and `held` drops on the same edge.
- Release racing hold expiry: `clean_out` falls on the edge where `hcnt` would reach 9 → no `held_pulse`, `fall_pulse`=1.
- Reset mid-hold: assert `rst` asynchronously while in HELD → all outputs go to 0 immediately. With the input still high after release, `rise_pulse` appears on edge 6.
- REPEAT_CYCLES=0 regression: hold ch1 for 40 cycles → a single `held_pulse` and no `repeat_pulse`.
